// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Drives a time-multiplexed, common-segment 7-segment display from a packed
// BCD word. It enables one digit per prescaler period and scans from digit 0
// up to digit DIGITS-1. Leading-zero blanking is optional. A newly loaded word
// is held until the next frame boundary, so a number is never shown half old
// and half new within one scan.
//
// Parameters
//   DIGITS    number of BCD digits / display positions (>= 2)
//   PRESCALE  clock cycles each digit stays enabled (>= 2)
//
// Ports
//   clk      in   1          sole clock, rising edge
//   rst      in   1          synchronous active-high reset
//   load     in   1          one-cycle strobe, bcd_in valid in the same cycle
//   bcd_in   in   4*DIGITS   packed BCD, bits [3:0] = digit 0 (least significant)
//   lzb      in   1          leading-zero blanking enable, sampled every cycle
//   seg      out  7          segments a..g on seg[0]..seg[6], active-high
//   dig_en   out  DIGITS     one-hot digit enable, bit i selects digit i
//   pending  out  1          a loaded word is waiting for the frame boundary
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  pending
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     disp;
  logic [BW-1:0]     pbuf;
  logic              pflag;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] dig_en_q;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic tick;
  logic frame_end;

  assign tick      = (cnt == CNT_LAST);
  // The last slot of the last digit is where a new word may be swapped in.
  assign frame_end = tick && (idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // 7-segment decode; any non-BCD nibble shows a single dash (segment g).
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Leading-zero blanking mask. Walk down from the most significant digit;
  // a digit is blanked while everything from it upward is zero. Invalid
  // nibbles are nonzero and therefore stop the run. Digit 0 is never blanked.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    blank    = '0;
    zero_run = lzb;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp[4*i +: 4] == 4'h0);
      blank[i] = zero_run;
    end
  end

  // Digit currently selected by the scan index.
  logic [3:0] cur_nib;
  logic       cur_blank;

  assign cur_nib   = disp[4*idx +: 4];
  assign cur_blank = blank[idx];

  // ---------------------------------------------------------------------------
  // Prescaler and scan index
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display word and pending buffer
  //   - load away from the boundary parks the word in pbuf (latest wins)
  //   - load on the boundary goes straight to disp and drops any parked word
  //   - boundary without load promotes a parked word, if any
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      disp  <= '0;
      pbuf  <= '0;
      pflag <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp <= bcd_in;
      end else if (pflag) begin
        disp <= pbuf;
      end
      pflag <= 1'b0;
    end else if (load) begin
      pbuf  <= bcd_in;
      pflag <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: one cycle behind idx/disp. A blanked digit still has
  // its enable asserted; only the segments go dark.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= 7'h00;
      dig_en_q <= '0;
    end else begin
      dig_en_q <= DIGITS'(1) << idx;
      seg_q    <= cur_blank ? 7'h00 : decode(cur_nib);
    end
  end

  assign seg     = seg_q;
  assign dig_en  = dig_en_q;
  assign pending = pflag;

endmodule
